dsc_s2b_decoder: RTL and testbench
==================================

# dsc_s2b_decoder

Stochastic-to-binary decoder for the deterministic stochastic computing (DSC) datapath. It sits at the consuming end of a serial unary bitstream, such as the output of a stochastic multiplier or another DSC arithmetic stage. It counts the ones in each framed bitstream and delivers the binary result through a one-entry valid/ready output buffer. Frames end either at the full deterministic length or early on an explicit `in_last` marker, which supports early-shutoff producers.

## Interface
Parameters:
- `SNG_WIDTH`, default 4: bit width of each operand's stream generator.
- `NUM_INPUTS`, default 2: number of operands combined into the stream.
- Derived, not overridable:
  - `W = NUM_INPUTS*SNG_WIDTH`.
  - `FRAME_LEN = 2**W`, which is 256 with the defaults.

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `sn_in` input, 1 bit: stochastic bit for the current beat.
- `in_valid` input, 1 bit: `sn_in` is valid this cycle.
- `in_last` input, 1 bit: the current beat is the final beat of the frame. Qualified by `in_valid`.
- `in_ready` output, 1 bit: decoder accepts a beat this cycle.
- `z` output, W+1 bits: ones count of the completed frame, range 0..FRAME_LEN.
- `out_valid` output, 1 bit: `z` holds an unconsumed result.
- `out_ready` input, 1 bit: downstream accepts `z`.
- `out_cycles` output, W+1 bits: beat count of the completed frame. Present only with `DSC_DEC_CYCLES_EN`.

## Operation
- A beat is accepted when `in_valid & in_ready`. Cycles with `in_valid=0` are not counted.
- Internal counters:
  - `ones_cnt` (W+1 bits) increments on each accepted beat with `sn_in=1`.
  - `beat_cnt` (W+1 bits) increments on each accepted beat.
- End of frame: an accepted beat with `in_last=1`, or an accepted beat with `beat_cnt == FRAME_LEN-1`, whichever comes first.
  - The final beat's `sn_in` is included in the result.
  - `in_last` on the FRAME_LEN-th beat is a single end, not two.
- States:
  - ACCUM: `in_ready=1`.
    - At end of frame, if the output buffer is free (`out_valid=0`, or `out_valid & out_ready` this cycle): load `z` (and `out_cycles`) with the final counts, set `out_valid`, clear both counters, stay in ACCUM.
    - At end of frame, if the buffer is not free: freeze the final counts and go to FULL.
  - FULL: `in_ready=0`; counters hold.
    - On `out_valid & out_ready`: load `z` from the frozen counts, keep `out_valid=1`, clear both counters, go to ACCUM.
- Output handshake:
  - `z` and `out_valid` hold stable while `out_valid & ~out_ready`.
  - `out_valid` clears on a handshake unless a new result loads on the same edge.
- No saturation is needed: the W+1 bit width covers an all-ones full frame (count FRAME_LEN).
- Reset, asynchronous with `rst=0`:
  - State goes to ACCUM and both counters clear.
  - `z=0`, `out_valid=0`, `out_cycles=0`.
  - `in_ready=0` while `rst` is asserted, and 1 from the first cycle after release.
  - Reset mid-frame discards the partial frame and any held result.

## Timing
- Result latency: `out_valid` rises on the edge that accepts the final beat and is visible the following cycle.
- Back-to-back frames run with zero bubbles when downstream keeps `out_ready=1`. Beat 0 of frame N+1 is accepted in the cycle after the last beat of frame N.
- FULL exit: the result loads on the handshake edge, and `in_ready` returns to 1 in the next cycle.
- `in_ready` is a registered function of state only. There is no combinational path from `out_ready` to `in_ready`.

## Configuration
- `DSC_DEC_CYCLES_EN` defined:
  - The `out_cycles` port and its register exist.
  - `out_cycles` is loaded together with `z`, equals the accepted beat count of the frame (1..FRAME_LEN), and is 0 after reset.
- Not defined:
  - The port and register are absent.
  - `beat_cnt` is still used internally for frame-end detection.
  - All other behaviour is identical.

## Test plan
- Full frame, all ones: 256 beats with `sn_in=1`, `out_ready=1` -> `z=256`, `out_valid` for 1 cycle, `out_cycles=256`.
- Full frame, 15 ones scattered among 256 beats, with random `in_valid` gaps -> `z=15`; gap cycles are not counted.
- Early termination: `in_last` on beat 10 with 7 ones -> `z=7`, `out_cycles=10`; the next frame starts counting from 0.
- Backpressure: `out_ready=0`; frame A (`z=3`) then frame B (`z=9`) complete.
  - `z` holds 3, state is FULL, `in_ready=0`.
  - Raise `out_ready` for 1 cycle -> `z=9`, `out_valid=1`, and `in_ready=1` on the next cycle.
- Reset mid-frame: assert `rst=0` after 100 beats -> all outputs 0 immediately. After release, a 256-beat frame with 40 ones -> `z=40`.
- Single-beat frame: `in_last` on beat 1 with `sn_in=1` -> `z=1`, `out_cycles=1`.

Source files
------------

// File: rtl/dsc_s2b_decoder.sv
// Stochastic-to-binary decoder: counts ones in each framed unary bitstream and hands the
// result out through a one-entry valid/ready buffer. Define DSC_DEC_CYCLES_EN to expose out_cycles.
module dsc_s2b_decoder #(
   parameter int SNG_WIDTH  = 4,
   parameter int NUM_INPUTS = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               sn_in,
   input  logic                               in_valid,
   input  logic                               in_last,
   output logic                               in_ready,
   output logic [NUM_INPUTS*SNG_WIDTH:0]      z,
   output logic                               out_valid,
   input  logic                               out_ready,
`ifdef DSC_DEC_CYCLES_EN
   output logic [NUM_INPUTS*SNG_WIDTH:0]      out_cycles,
`endif
   output logic                               fsm_state
);

   localparam int W         = NUM_INPUTS * SNG_WIDTH;
   localparam int FRAME_LEN = 2 ** W;
   localparam logic [W:0] LAST_BEAT = (W + 1)'(FRAME_LEN - 1);

   // Handshakes: a beat moves on in_valid & in_ready, a result on out_valid & out_ready,
   // both at the rising edge; a producer never retracts an asserted valid.
   typedef enum logic {ACCUM = 1'b0, FULL = 1'b1} state_t;

   state_t     st;
   logic [W:0] ones_cnt;
   logic [W:0] beat_cnt;
   logic [W:0] ones_next;
   logic [W:0] beat_next;
   logic       accept;
   logic       frame_end;
   logic       buf_free;

   always_comb begin
      accept    = in_valid & in_ready;
      ones_next = ones_cnt + {{W{1'b0}}, sn_in};
      beat_next = beat_cnt + {{W{1'b0}}, 1'b1};
      frame_end = accept & (in_last | (beat_cnt == LAST_BEAT));
      buf_free  = ~out_valid | out_ready;
   end

   assign fsm_state = st;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st         <= ACCUM;
         ones_cnt   <= '0;
         beat_cnt   <= '0;
         z          <= '0;
         out_valid  <= 1'b0;
         in_ready   <= 1'b0;
`ifdef DSC_DEC_CYCLES_EN
         out_cycles <= '0;
`endif
      end else begin
         case (st)
            ACCUM: begin
               in_ready <= 1'b1;
               if (out_valid & out_ready)
                  out_valid <= 1'b0;
               if (frame_end) begin
                  if (buf_free) begin
                     z          <= ones_next;
`ifdef DSC_DEC_CYCLES_EN
                     out_cycles <= beat_next;
`endif
                     out_valid  <= 1'b1;
                     ones_cnt   <= '0;
                     beat_cnt   <= '0;
                  end else begin
                     // Buffer still occupied: park the finished counts and stall input.
                     ones_cnt <= ones_next;
                     beat_cnt <= beat_next;
                     st       <= FULL;
                     in_ready <= 1'b0;
                  end
               end else if (accept) begin
                  ones_cnt <= ones_next;
                  beat_cnt <= beat_next;
               end
            end
            FULL: begin
               if (out_ready) begin
                  z          <= ones_cnt;
`ifdef DSC_DEC_CYCLES_EN
                  out_cycles <= beat_cnt;
`endif
                  ones_cnt   <= '0;
                  beat_cnt   <= '0;
                  st         <= ACCUM;
                  in_ready   <= 1'b1;
               end
            end
            default: begin
               st       <= ACCUM;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dsc_s2b_decoder.sv
// Bench for dsc_s2b_decoder: directed frames feed a frame-level model (expected queue of
// {ones, beats}) that a per-cycle compare process checks at every output handshake.
module tb_dsc_s2b_decoder;

   localparam int W  = 8;
   localparam int FL = 256;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sn_in = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic       fsm_state;
   logic [W:0] z;
`ifdef DSC_DEC_CYCLES_EN
   logic [W:0] out_cycles;
`endif

   dsc_s2b_decoder #(.SNG_WIDTH(4), .NUM_INPUTS(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .sn_in      (sn_in),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .z          (z),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
`ifdef DSC_DEC_CYCLES_EN
      .out_cycles (out_cycles),
`endif
      .fsm_state  (fsm_state)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cur_ones = 0;
   int cur_beats = 0;
   int hs_cnt = 0;
   int ov_cycles = 0;
   int got_z = -1;
   int got_cyc = -1;
   logic [2*W+1:0] exp_q[$];
   logic       prev_stall = 1'b0;
   logic [W:0] prev_z = '0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Compare process: outputs are stable at the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         logic [2*W+1:0] e;
         if (out_valid) ov_cycles++;
         if (prev_stall) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_z", int'(z), int'(prev_z));
         end
         if (out_valid && out_ready) begin
            hs_cnt++;
            got_z = int'(z);
`ifdef DSC_DEC_CYCLES_EN
            got_cyc = int'(out_cycles);
`endif
            if (exp_q.size() == 0) begin
               check("unexpected_result", 0, 1);
            end else begin
               e = exp_q.pop_front();
               check("z", int'(z), int'(e[2*W+1:W+1]));
`ifdef DSC_DEC_CYCLES_EN
               check("out_cycles", int'(out_cycles), int'(e[W:0]));
`endif
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_z     = z;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // Offer one beat until accepted; the model closes a frame on in_last or on the FL-th beat.
   task automatic beat(input logic b, input logic last);
      int   guard;
      logic acc;
      guard = 0;
      sn_in = b; in_last = last; in_valid = 1'b1;
      do begin
         acc = in_ready;
         cyc();
         guard++;
      end while (!acc && guard < 2000);
      in_valid = 1'b0; in_last = 1'b0; sn_in = 1'b0;
      if (!acc) begin
         check("beat_timeout", 0, 1);
      end else begin
         cur_beats++;
         cur_ones += int'(b);
         if (last || cur_beats == FL) begin
            exp_q.push_back({(W + 1)'(cur_ones), (W + 1)'(cur_beats)});
            cur_ones  = 0;
            cur_beats = 0;
         end
      end
   endtask

   task automatic check_cycles(input string name, input int exp);
`ifdef DSC_DEC_CYCLES_EN
      check(name, got_cyc, exp);
`else
      if (exp < 0) check(name, got_cyc, exp);
`endif
   endtask

   initial begin
      int h0;
      #3;
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_z", int'(z), 0);
      check("rst_state", int'(fsm_state), 0);
`ifdef DSC_DEC_CYCLES_EN
      check("rst_out_cycles", int'(out_cycles), 0);
`endif
      cyc(); cyc();
      rst = 1'b1;
      cyc();
      check("in_ready_after_rst", int'(in_ready), 1);

      // Full frame, all ones.
      out_ready = 1'b1;
      ov_cycles = 0;
      h0 = hs_cnt;
      for (int i = 0; i < FL; i++) beat(1'b1, 1'b0);
      idle(4);
      check("all_ones_z", got_z, 256);
      check_cycles("all_ones_cycles", 256);
      check("all_ones_results", hs_cnt - h0, 1);
      check("all_ones_valid_cycles", ov_cycles, 1);

      // 15 scattered ones with idle gaps.
      for (int i = 0; i < FL; i++) begin
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         beat(((i % 17) == 0) && (i < 255), 1'b0);
      end
      idle(4);
      check("scattered_z", got_z, 15);
      check_cycles("scattered_cycles", 256);

      // Early termination at beat 10, then a single-beat frame.
      for (int i = 0; i < 10; i++) beat(i < 7, i == 9);
      idle(3);
      check("early_z", got_z, 7);
      check_cycles("early_cycles", 10);
      beat(1'b1, 1'b1);
      idle(3);
      check("single_z", got_z, 1);
      check_cycles("single_cycles", 1);

      // in_last on the 256th beat ends one frame only.
      h0 = hs_cnt;
      for (int i = 0; i < FL; i++) beat(i[0], i == FL - 1);
      idle(4);
      check("last_at_full_z", got_z, 128);
      check("last_at_full_results", hs_cnt - h0, 1);

      // Backpressure: A (3 ones) held, B (9 ones) parked in FULL.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) beat(i < 3, i == 4);
      for (int i = 0; i < 12; i++) beat(i < 9, i == 11);
      check("bp_z_held", int'(z), 3);
      check("bp_valid", int'(out_valid), 1);
      check("bp_state_full", int'(fsm_state), 1);
      check("bp_in_ready", int'(in_ready), 0);
      idle(2);
      check("bp_in_ready_still", int'(in_ready), 0);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      check("bp_popped_a", got_z, 3);
      check("bp_z_b", int'(z), 9);
      check("bp_valid_b", int'(out_valid), 1);
      check("bp_in_ready_back", int'(in_ready), 1);
      check("bp_state_accum", int'(fsm_state), 0);
      out_ready = 1'b1;
      idle(3);
      check("bp_popped_b", got_z, 9);
      check_cycles("bp_cycles_b", 12);

      // Reset mid-frame with a held result pending.
      out_ready = 1'b0;
      beat(1'b1, 1'b1);
      for (int i = 0; i < 100; i++) beat(1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_z", int'(z), 0);
      check("midrst_valid", int'(out_valid), 0);
      check("midrst_in_ready", int'(in_ready), 0);
      exp_q.delete();
      cur_ones = 0;
      cur_beats = 0;
      cyc(); cyc();
      rst = 1'b1;
      out_ready = 1'b1;
      cyc();
      check("midrst_in_ready_after", int'(in_ready), 1);
      for (int i = 0; i < FL; i++) beat(((i % 6) == 0) && (i < 240), 1'b0);
      idle(4);
      check("after_rst_z", got_z, 40);
      check_cycles("after_rst_cycles", 256);

      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
